// File: rtl/cache_ctrl.sv
// Set-update controller: reads a set, applies MESI/LRU rules, writes it back; accept->done 3 cycles (n 8/9/other: 2), cmd_ready only when idle.
// Statistics counters are built only when CACHE_CTRL_STATS_EN is defined; otherwise they read as 0.
module cache_ctrl #(
    parameter int SETS = 16384,
    parameter int WAYS = 8,
    localparam int IDX_W  = $clog2(SETS),
    localparam int LRU_W  = $clog2(WAYS),
    localparam int TAG_W  = 12,
    localparam int DATA_W = 32,
    localparam int CMD_W  = 4 + TAG_W + IDX_W,
    localparam int LINE_W = TAG_W + 2 + LRU_W + DATA_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [CMD_W-1:0]         cmd,
    output logic [CMD_W-1:0]         st_cmd,
    input  logic [WAYS*LINE_W-1:0]   st_rdata,
    output logic [WAYS*LINE_W-1:0]   st_wdata,
    output logic                     hit,
    output logic                     miss,
    output logic                     done,
    output logic                     wb_valid,
    output logic [TAG_W-1:0]         wb_tag,
    output logic [31:0]              rd_cnt,
    output logic [31:0]              wr_cnt,
    output logic [31:0]              hit_cnt,
    output logic [31:0]              miss_cnt
);
    localparam int DATA_LSB = 0;
    localparam int LRU_LSB  = DATA_W;
    localparam int MESI_LSB = DATA_W + LRU_W;
    localparam int TAG_LSB  = DATA_W + LRU_W + 2;

    localparam logic [1:0] ST_IDLE = 2'd0, ST_LOOKUP = 2'd1, ST_UPDATE = 2'd2, ST_FIN = 2'd3;
    localparam logic [1:0] MESI_I = 2'd0, MESI_S = 2'd1, MESI_E = 2'd2, MESI_M = 2'd3;
    localparam logic [CMD_W-1:0] IDLE_CMD = {4'hF, {(CMD_W-4){1'b0}}};

    logic [1:0]             state_q, state_d;
    logic [CMD_W-1:0]       st_cmd_q, st_cmd_d;
    logic [WAYS*LINE_W-1:0] rdata_q, rdata_d;
    logic                   hit_q, hit_d, miss_q, miss_d, done_q, done_d, wb_valid_q, wb_valid_d;
    logic [TAG_W-1:0]       wb_tag_q, wb_tag_d;

    logic [3:0]             cur_n;
    logic [TAG_W-1:0]       cur_tag;
    logic                   upd_rw, hit_found, inv_found, upd_wb;
    logic [LRU_W-1:0]       hit_way, inv_way, lru_way, acc_way, old_lru;
    logic [TAG_W-1:0]       upd_wb_tag;
    logic [WAYS*LINE_W-1:0] new_set;

    // Set update computed from the registered lookup data; only meaningful in UPDATE.
    always_comb begin
        cur_n      = st_cmd_q[CMD_W-1 -: 4];
        cur_tag    = st_cmd_q[IDX_W +: TAG_W];
        upd_rw     = (cur_n <= 4'd2);
        hit_found  = 1'b0;
        inv_found  = 1'b0;
        hit_way    = '0;
        inv_way    = '0;
        lru_way    = '0;
        for (int w = WAYS-1; w >= 0; w--) begin
            if (rdata_q[w*LINE_W+TAG_LSB +: TAG_W] == cur_tag &&
                rdata_q[w*LINE_W+MESI_LSB +: 2] != MESI_I) begin
                hit_found = 1'b1;
                hit_way   = LRU_W'(w);
            end
            if (rdata_q[w*LINE_W+MESI_LSB +: 2] == MESI_I) begin
                inv_found = 1'b1;
                inv_way   = LRU_W'(w);
            end
            if (rdata_q[w*LINE_W+LRU_LSB +: LRU_W] == LRU_W'(WAYS-1)) begin
                lru_way = LRU_W'(w);
            end
        end
        acc_way = hit_found ? hit_way : (inv_found ? inv_way : lru_way);
        old_lru = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (LRU_W'(w) == acc_way) old_lru = rdata_q[w*LINE_W+LRU_LSB +: LRU_W];
        end
        new_set    = rdata_q;
        upd_wb     = 1'b0;
        upd_wb_tag = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (upd_rw) begin
                if (LRU_W'(w) == acc_way) begin
                    new_set[w*LINE_W+LRU_LSB +: LRU_W] = '0;
                    if (!hit_found) begin
                        if (rdata_q[w*LINE_W+MESI_LSB +: 2] == MESI_M) begin
                            upd_wb     = 1'b1;
                            upd_wb_tag = rdata_q[w*LINE_W+TAG_LSB +: TAG_W];
                        end
                        new_set[w*LINE_W+TAG_LSB +: TAG_W]   = cur_tag;
                        new_set[w*LINE_W+DATA_LSB +: DATA_W] = '0;
                    end
                    if (cur_n == 4'd1)   new_set[w*LINE_W+MESI_LSB +: 2] = MESI_M;
                    else if (!hit_found) new_set[w*LINE_W+MESI_LSB +: 2] = MESI_E;
                end else if (rdata_q[w*LINE_W+LRU_LSB +: LRU_W] < old_lru) begin
                    new_set[w*LINE_W+LRU_LSB +: LRU_W] = rdata_q[w*LINE_W+LRU_LSB +: LRU_W] + 1'b1;
                end
            end else if (hit_found && LRU_W'(w) == hit_way) begin
                if (cur_n == 4'd3) begin
                    new_set[w*LINE_W+MESI_LSB +: 2] = MESI_I;
                end else if (cur_n == 4'd4) begin
                    if (rdata_q[w*LINE_W+MESI_LSB +: 2] == MESI_M) begin
                        upd_wb     = 1'b1;
                        upd_wb_tag = rdata_q[w*LINE_W+TAG_LSB +: TAG_W];
                    end
                    new_set[w*LINE_W+MESI_LSB +: 2] = MESI_S;
                end
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        st_cmd_d   = st_cmd_q;
        rdata_d    = (state_q == ST_LOOKUP) ? st_rdata : rdata_q;
        hit_d      = 1'b0;
        miss_d     = 1'b0;
        done_d     = 1'b0;
        wb_valid_d = 1'b0;
        wb_tag_d   = wb_tag_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    st_cmd_d = cmd;
                    state_d  = (cmd[CMD_W-1 -: 4] <= 4'd4) ? ST_LOOKUP : ST_FIN;
                end
            end
            ST_LOOKUP: state_d = ST_UPDATE;
            ST_UPDATE: begin
                state_d    = ST_IDLE;
                st_cmd_d   = IDLE_CMD;
                done_d     = 1'b1;
                hit_d      = upd_rw && hit_found;
                miss_d     = upd_rw && !hit_found;
                wb_valid_d = upd_wb;
                if (upd_wb) wb_tag_d = upd_wb_tag;
            end
            default: begin
                state_d  = ST_IDLE;
                st_cmd_d = IDLE_CMD;
                done_d   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            st_cmd_q   <= IDLE_CMD;
            rdata_q    <= '0;
            hit_q      <= 1'b0;
            miss_q     <= 1'b0;
            done_q     <= 1'b0;
            wb_valid_q <= 1'b0;
            wb_tag_q   <= '0;
        end else begin
            state_q    <= state_d;
            st_cmd_q   <= st_cmd_d;
            rdata_q    <= rdata_d;
            hit_q      <= hit_d;
            miss_q     <= miss_d;
            done_q     <= done_d;
            wb_valid_q <= wb_valid_d;
            wb_tag_q   <= wb_tag_d;
        end
    end

    assign cmd_ready = (state_q == ST_IDLE);
    assign st_cmd    = st_cmd_q;
    // A reset landing in UPDATE must not commit the set, so the write-back is gated by rst.
    assign st_wdata  = (state_q == ST_UPDATE && !rst) ? new_set : st_rdata;
    assign hit       = hit_q;
    assign miss      = miss_q;
    assign done      = done_q;
    assign wb_valid  = wb_valid_q;
    assign wb_tag    = wb_tag_q;

`ifdef CACHE_CTRL_STATS_EN
    logic [31:0] rd_cnt_q, wr_cnt_q, hit_cnt_q, miss_cnt_q;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst || (state_q == ST_FIN && cur_n == 4'd8)) begin
            rd_cnt_q   <= '0;
            wr_cnt_q   <= '0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else if (state_q == ST_UPDATE) begin
            if (cur_n == 4'd0 || cur_n == 4'd2) rd_cnt_q <= sat_inc(rd_cnt_q);
            if (cur_n == 4'd1) wr_cnt_q <= sat_inc(wr_cnt_q);
            if (hit_d)  hit_cnt_q  <= sat_inc(hit_cnt_q);
            if (miss_d) miss_cnt_q <= sat_inc(miss_cnt_q);
        end
    end

    assign rd_cnt   = rd_cnt_q;
    assign wr_cnt   = wr_cnt_q;
    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`else
    assign rd_cnt   = '0;
    assign wr_cnt   = '0;
    assign hit_cnt  = '0;
    assign miss_cnt = '0;
`endif
endmodule
